// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, FSM state codes
// and the opcode legality check used before anything reaches the ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    // Arbiter FSM encoding; plain constants so older tools and netlists agree
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // True only for opcodes the ALU actually implements
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: starting at the rotating pointer,
// returns the first valid requester as a one-hot grant and as an index.
module rr_pick
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] i_req_valid,
    input  logic [IW-1:0]   i_rr_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_grant_idx,
    output logic            o_any
);

    // Walk the requesters in priority order from the pointer, keep the first hit
    always_comb begin
        int c;
        c           = 0;
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(i_rr_ptr) + k;
            if (c >= NREQ) begin
                c = c - NREQ;
            end
            if (!o_any && i_req_valid[c]) begin
                o_any       = 1'b1;
                o_grant[c]  = 1'b1;
                o_grant_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU among NREQ requesters. One operation in flight,
// round-robin grant, valid/ready on both the request and response sides.
// Illegal opcodes are answered directly with an error and never reach the ALU.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_src1,
    input  logic [NREQ*DW-1:0] req_src2,
    input  logic [NREQ*4-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [DW-1:0]     rsp_result,
    output logic [2:0]        rsp_zcv,
    output logic              rsp_err,
    output logic [DW-1:0]     alu_src1,
    output logic [DW-1:0]     alu_src2,
    output logic [3:0]        alu_ctrl,
    input  logic [DW-1:0]     alu_result,
    input  logic [2:0]        alu_zcv
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [1:0]      r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_gnt_idx;
    logic [CW-1:0]   r_wait_cnt;
    logic [DW-1:0]   r_alu_src1;
    logic [DW-1:0]   r_alu_src2;
    logic [3:0]      r_alu_ctrl;
    logic [DW-1:0]   r_rsp_result;
    logic [2:0]      r_rsp_zcv;
    logic            r_rsp_err;

    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_grant_idx;
    logic            w_any;
    logic [DW-1:0]   w_sel_src1;
    logic [DW-1:0]   w_sel_src2;
    logic [3:0]      w_sel_op;
    logic            w_op_legal;
    logic            w_rsp_take;

    rr_pick #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_rr_pick (
        .i_req_valid(req_valid),
        .i_rr_ptr   (r_rr_ptr),
        .o_grant    (w_grant),
        .o_grant_idx(w_grant_idx),
        .o_any      (w_any)
    );

    // Route the granted requester's operands and opcode toward the ALU registers
    always_comb begin
        w_sel_src1 = '0;
        w_sel_src2 = '0;
        w_sel_op   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_idx == IW'(k)) begin
                w_sel_src1 = req_src1[k*DW +: DW];
                w_sel_src2 = req_src2[k*DW +: DW];
                w_sel_op   = req_op[k*4 +: 4];
            end
        end
    end

    assign w_op_legal = op_is_legal(w_sel_op);

    // Accept strobe only while idle and out of reset; response strobe follows the stored grant
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (rst_n && (r_state == ST_IDLE)) begin
            req_ready = w_grant;
        end
        for (int k = 0; k < NREQ; k++) begin
            rsp_valid[k] = (r_state == ST_RESP) && (r_gnt_idx == IW'(k));
        end
    end

    assign w_rsp_take = |(rsp_valid & rsp_ready);

    // Arbitration FSM: accept, issue to ALU, wait out its latency, hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_gnt_idx    <= '0;
            r_wait_cnt   <= '0;
            r_alu_src1   <= '0;
            r_alu_src2   <= '0;
            r_alu_ctrl   <= '0;
            r_rsp_result <= '0;
            r_rsp_zcv    <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt_idx <= w_grant_idx;
                        r_rr_ptr  <= (w_grant_idx == IW'(NREQ - 1)) ? '0 : (w_grant_idx + 1'b1);
                        if (w_op_legal) begin
                            r_alu_src1 <= w_sel_src1;
                            r_alu_src2 <= w_sel_src2;
                            r_alu_ctrl <= w_sel_op;
                            r_state    <= ST_ISSUE;
                        end else begin
                            r_rsp_result <= '0;
                            r_rsp_zcv    <= '0;
                            r_rsp_err    <= 1'b1;
                            r_state      <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= CW'(ALU_LAT - 1);
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_rsp_result <= alu_result;
                        r_rsp_zcv    <= alu_zcv;
                        r_rsp_err    <= 1'b0;
                        r_state      <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_take) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_src1   = r_alu_src1;
    assign alu_src2   = r_alu_src2;
    assign alu_ctrl   = r_alu_ctrl;
    assign rsp_result = r_rsp_result;
    assign rsp_zcv    = r_rsp_zcv;
    assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU drives the result
// inputs, a scoreboard records each accepted request and checks the response.
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    typedef struct {
        int            idx;
        logic [DW-1:0] result;
        logic [2:0]    zcv;
        logic          err;
        int            acceptCycle;
    } sbEntry_t;

    logic clk = 1'b0;
    logic rstN;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;
    sbEntry_t sbQueue[$];

    // Unit A: ALU latency 1
    logic [NREQ-1:0]    reqValid, reqReady, rspValid, rspReady;
    logic [NREQ*DW-1:0] reqSrc1, reqSrc2;
    logic [NREQ*4-1:0]  reqOp;
    logic [DW-1:0]      rspResult, aluSrc1, aluSrc2, aluResult;
    logic [2:0]         rspZcv, aluZcv;
    logic               rspErr;
    logic [3:0]         aluCtrl;
    logic [DW+2:0]      pipeA;

    // Unit B: ALU latency 3
    logic [NREQ-1:0]    reqValidB, reqReadyB, rspValidB, rspReadyB;
    logic [NREQ*DW-1:0] reqSrc1B, reqSrc2B;
    logic [NREQ*4-1:0]  reqOpB;
    logic [DW-1:0]      rspResultB, aluSrc1B, aluSrc2B, aluResultB;
    logic [2:0]         rspZcvB, aluZcvB;
    logic               rspErrB;
    logic [3:0]         aluCtrlB;
    logic [DW+2:0]      pipeB [3];

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .DW(DW), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rstN),
        .req_valid(reqValid), .req_ready(reqReady),
        .req_src1(reqSrc1), .req_src2(reqSrc2), .req_op(reqOp),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_result(rspResult), .rsp_zcv(rspZcv), .rsp_err(rspErr),
        .alu_src1(aluSrc1), .alu_src2(aluSrc2), .alu_ctrl(aluCtrl),
        .alu_result(aluResult), .alu_zcv(aluZcv)
    );

    alu_arbiter #(.NREQ(NREQ), .DW(DW), .ALU_LAT(3)) dutLat3 (
        .clk(clk), .rst_n(rstN),
        .req_valid(reqValidB), .req_ready(reqReadyB),
        .req_src1(reqSrc1B), .req_src2(reqSrc2B), .req_op(reqOpB),
        .rsp_valid(rspValidB), .rsp_ready(rspReadyB),
        .rsp_result(rspResultB), .rsp_zcv(rspZcvB), .rsp_err(rspErrB),
        .alu_src1(aluSrc1B), .alu_src2(aluSrc2B), .alu_ctrl(aluCtrlB),
        .alu_result(aluResultB), .alu_zcv(aluZcvB)
    );

    // Reference ALU: returns {result, zero, cout, overflow}
    function automatic logic [DW+2:0] aluCompute(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0]   s;
        logic [DW-1:0] r;
        logic          c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin
                s = {1'b0, a} + {1'b0, b};
                r = s[DW-1:0]; c = s[DW];
                v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            4'd6:  begin
                s = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
                r = s[DW-1:0]; c = s[DW];
                v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            4'd12: r = ~(a | b);
            default: r = '0;
        endcase
        return {r, (r == '0), c, v};
    endfunction

    function automatic bit isLegalOp(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd6) || (op == 4'd7) || (op == 4'd12);
    endfunction

    // Single-cycle ALU model for unit A
    always @(posedge clk) pipeA <= aluCompute(aluCtrl, aluSrc1, aluSrc2);
    assign {aluResult, aluZcv} = pipeA;

    // Three-stage ALU model for unit B
    always @(posedge clk) begin
        pipeB[0] <= aluCompute(aluCtrlB, aluSrc1B, aluSrc2B);
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign {aluResultB, aluZcvB} = pipeB[2];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Cycle counter, advanced on each active edge
    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Scoreboard monitor: push on accept, compare while a response is presented
    initial begin
        sbEntry_t      e;
        int            g;
        logic [3:0]    op;
        logic [DW+2:0] res;
        bit            prevRspValid;
        prevRspValid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                sbQueue.delete();
                prevRspValid = 1'b0;
            end else begin
                if (reqReady != '0) begin
                    checkOutput("readyOneHot", 64'($onehot(reqReady)), 64'd1);
                    g = 0;
                    for (int k = NREQ - 1; k >= 0; k--) if (reqReady[k]) g = k;
                    op = reqOp[g*4 +: 4];
                    e.idx = g;
                    e.acceptCycle = cycle;
                    if (isLegalOp(op)) begin
                        res = aluCompute(op, reqSrc1[g*DW +: DW], reqSrc2[g*DW +: DW]);
                        e.result = res[DW+2:3];
                        e.zcv = res[2:0];
                        e.err = 1'b0;
                    end else begin
                        e.result = '0;
                        e.zcv = 3'b000;
                        e.err = 1'b1;
                    end
                    sbQueue.push_back(e);
                end
                if (rspValid != '0) begin
                    if (sbQueue.size() == 0) begin
                        checkOutput("unexpectedRsp", 64'(rspValid), 64'd0);
                    end else begin
                        e = sbQueue[0];
                        checkOutput("rspValidBit", 64'(rspValid), 64'(1) << e.idx);
                        checkOutput("rspResult", 64'(rspResult), 64'(e.result));
                        checkOutput("rspZcv", 64'(rspZcv), 64'(e.zcv));
                        checkOutput("rspErr", 64'(rspErr), 64'(e.err));
                        if (!prevRspValid) begin
                            checkOutput("rspLatency", 64'(cycle - e.acceptCycle), e.err ? 64'd1 : 64'd3);
                        end
                        if ((rspValid & rspReady) != '0) void'(sbQueue.pop_front());
                    end
                end
                prevRspValid = (rspValid != '0);
            end
        end
    end

    task automatic applyStimulus(input int idx, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        reqOp[idx*4 +: 4]    = op;
        reqSrc1[idx*DW +: DW] = a;
        reqSrc2[idx*DW +: DW] = b;
        reqValid[idx]         = 1'b1;
    endtask

    task automatic waitAccept(input int idx, output int acceptCycle);
        acceptCycle = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (reqReady[idx]) begin
                acceptCycle = cycle;
                break;
            end
        end
        if (acceptCycle < 0) checkOutput($sformatf("acceptTimeout%0d", idx), 64'd0, 64'd1);
    endtask

    task automatic waitAny(output int g, output int acceptCycle);
        g = -1;
        acceptCycle = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (reqReady != '0) begin
                for (int k = NREQ - 1; k >= 0; k--) if (reqReady[k]) g = k;
                acceptCycle = cycle;
                break;
            end
        end
        if (g < 0) checkOutput("grantTimeout", 64'd0, 64'd1);
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (sbQueue.size() == 0 && rspValid == '0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput("drainTimeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    // Guard against a stuck run
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, g, last;
        logic [DW-1:0] savedSrc1, savedSrc2;
        logic [3:0]    savedCtrl;

        rstN = 1'b0;
        reqValid = '1; reqSrc1 = '0; reqSrc2 = '0; reqOp = '0; rspReady = '1;
        reqValidB = '0; reqSrc1B = '0; reqSrc2B = '0; reqOpB = '0; rspReadyB = '1;

        // Reset state, with all requests raised to show ready is gated
        @(negedge clk);
        checkOutput("resetReqReady", 64'(reqReady), 64'd0);
        checkOutput("resetRspValid", 64'(rspValid), 64'd0);
        checkOutput("resetResult", 64'(rspResult), 64'd0);
        checkOutput("resetZcv", 64'(rspZcv), 64'd0);
        checkOutput("resetErr", 64'(rspErr), 64'd0);
        checkOutput("resetAluSrc1", 64'(aluSrc1), 64'd0);
        checkOutput("resetAluSrc2", 64'(aluSrc2), 64'd0);
        checkOutput("resetAluCtrl", 64'(aluCtrl), 64'd0);
        reqValid = '0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD with signed overflow
        $display("[TB] single request");
        applyStimulus(0, 4'd2, 32'h7FFF_FFFF, 32'h0000_0001);
        waitAccept(0, t);
        checkOutput("t1ReadyOneHot", 64'(reqReady), 64'b0001);
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k < 3) checkOutput("t1NoEarlyRsp", 64'(rspValid), 64'd0);
        end
        checkOutput("t1RspValid", 64'(rspValid), 64'b0001);
        checkOutput("t1Result", 64'(rspResult), 64'h8000_0000);
        checkOutput("t1Zcv", 64'(rspZcv), 64'b001);
        checkOutput("t1Err", 64'(rspErr), 64'd0);
        waitDrain();

        // Round-robin with every requester asking continuously
        $display("[TB] round robin");
        doReset();
        for (int k = 0; k < NREQ; k++) begin
            applyStimulus(k, 4'd0, 32'hF0F0_0000 | 32'(k * 17), 32'h0FFF_FF00 | 32'(k));
        end
        last = 0;
        for (int k = 0; k < 5; k++) begin
            waitAny(g, t);
            checkOutput($sformatf("t2Grant%0d", k), 64'(g), 64'(k % NREQ));
            if (k > 0) checkOutput($sformatf("t2Spacing%0d", k), 64'(t - last), 64'd4);
            last = t;
            @(posedge clk);
            #1;
        end
        reqValid = '0;
        waitDrain();

        // Backpressure on requester 2 while requester 1 waits
        $display("[TB] backpressure");
        rspReady = 4'b1011;
        applyStimulus(2, 4'd6, 32'd5, 32'd5);
        waitAccept(2, t);
        @(posedge clk);
        #1;
        reqValid[2] = 1'b0;
        applyStimulus(1, 4'd2, 32'd3, 32'd4);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rspValid != '0) break;
        end
        for (int n = 0; n < 6; n++) begin
            checkOutput("t3HeldValid", 64'(rspValid), 64'b0100);
            checkOutput("t3HeldResult", 64'(rspResult), 64'd0);
            checkOutput("t3HeldZcv", 64'(rspZcv), 64'b110);
            checkOutput("t3Req1Waits", 64'(reqReady), 64'd0);
            if (n < 5) @(negedge clk);
        end
        @(posedge clk);
        #1;
        rspReady[2] = 1'b1;
        @(negedge clk);
        checkOutput("t3HandshakeValid", 64'(rspValid), 64'b0100);
        checkOutput("t3HandshakeNoAccept", 64'(reqReady), 64'd0);
        @(negedge clk);
        checkOutput("t3Req1Accept", 64'(reqReady), 64'b0010);
        @(posedge clk);
        #1;
        reqValid[1] = 1'b0;
        rspReady = '1;
        waitDrain();

        // Illegal opcode is answered without touching the ALU
        $display("[TB] illegal opcode");
        savedSrc1 = aluSrc1;
        savedSrc2 = aluSrc2;
        savedCtrl = aluCtrl;
        applyStimulus(3, 4'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        waitAccept(3, t);
        @(posedge clk);
        #1;
        reqValid[3] = 1'b0;
        @(negedge clk);
        checkOutput("t4RspValid", 64'(rspValid), 64'b1000);
        checkOutput("t4Result", 64'(rspResult), 64'd0);
        checkOutput("t4Zcv", 64'(rspZcv), 64'd0);
        checkOutput("t4Err", 64'(rspErr), 64'd1);
        checkOutput("t4AluSrc1", 64'(aluSrc1), 64'(savedSrc1));
        checkOutput("t4AluSrc2", 64'(aluSrc2), 64'(savedSrc2));
        checkOutput("t4AluCtrl", 64'(aluCtrl), 64'(savedCtrl));
        waitDrain();

        // Reset while the ALU operation is pending
        $display("[TB] reset mid-operation");
        applyStimulus(0, 4'd2, 32'd1, 32'd2);
        waitAccept(0, t);
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("t5RspValid", 64'(rspValid), 64'd0);
        checkOutput("t5Result", 64'(rspResult), 64'd0);
        checkOutput("t5Zcv", 64'(rspZcv), 64'd0);
        checkOutput("t5Err", 64'(rspErr), 64'd0);
        checkOutput("t5AluSrc1", 64'(aluSrc1), 64'd0);
        checkOutput("t5AluSrc2", 64'(aluSrc2), 64'd0);
        checkOutput("t5AluCtrl", 64'(aluCtrl), 64'd0);
        checkOutput("t5ReqReady", 64'(reqReady), 64'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            checkOutput("t5NoRsp", 64'(rspValid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(2, 4'd1, 32'h0000_00F0, 32'h0000_000F);
        applyStimulus(0, 4'd12, 32'h0000_FFFF, 32'hFFFF_0000);
        waitAny(g, t);
        checkOutput("t5GrantAfterReset", 64'(g), 64'd0);
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        waitAccept(2, t);
        @(posedge clk);
        #1;
        reqValid[2] = 1'b0;
        waitDrain();

        // Three-cycle ALU: signed compare, response five cycles after accept
        $display("[TB] latency-3 unit");
        reqOpB[1*4 +: 4]     = 4'd7;
        reqSrc1B[1*DW +: DW] = 32'hFFFF_FFFF;
        reqSrc2B[1*DW +: DW] = 32'h0000_0001;
        reqValidB[1]         = 1'b1;
        t = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (reqReadyB[1]) begin
                t = cycle;
                break;
            end
        end
        checkOutput("t6ReadyOneHot", 64'(reqReadyB), 64'b0010);
        @(posedge clk);
        #1;
        reqValidB[1] = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rspValidB != '0) break;
        end
        checkOutput("t6Latency", 64'(cycle - t), 64'd5);
        checkOutput("t6RspValid", 64'(rspValidB), 64'b0010);
        checkOutput("t6Result", 64'(rspResultB), 64'd1);
        checkOutput("t6Zcv", 64'(rspZcvB), 64'd0);
        checkOutput("t6Err", 64'(rspErrB), 64'd0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
